// File: rtl/comp_select_n_pkg.sv
// Shared definitions for the compressor-channel selector: channel index width,
// header field placement and FSM state encoding.
package comp_select_n_pkg;

    function automatic int ch_w_of(input int num_ch);
        return (num_ch > 1) ? $clog2(num_ch) : 1;
    endfunction

    // Header word: winning channel index in the top bits, its block size in the low bits.
    function automatic int hdr_sel_msb(input int d_bitwidth);
        return d_bitwidth - 1;
    endfunction

    localparam int HDR_SIZE_LSB = 0;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SEL    = 3'd1,
        ST_HDR    = 3'd2,
        ST_STREAM = 3'd3,
        ST_DRAIN  = 3'd4
    } state_t;

endpackage

// File: rtl/comp_min_select.sv
// Combinational NUM_CH-way minimum; on equal values the lowest index wins.
module comp_min_select
    import comp_select_n_pkg::*;
#(
    parameter int NUM_CH = 3,
    parameter int VAL_W  = 11,
    localparam int IDX_W = ch_w_of(NUM_CH)
) (
    input  logic [NUM_CH*VAL_W-1:0] vals,
    output logic [IDX_W-1:0]        min_idx,
    output logic [VAL_W-1:0]        min_val
);

    always_comb begin
        min_val = vals[VAL_W-1:0];
        min_idx = '0;
        // Strict less-than keeps the earlier channel on ties.
        for (int k = 1; k < NUM_CH; k++) begin
            if (vals[k*VAL_W +: VAL_W] < min_val) begin
                min_val = vals[k*VAL_W +: VAL_W];
                min_idx = IDX_W'(k);
            end
        end
    end

endmodule

// File: rtl/comp_select_n.sv
// Picks the channel with the smallest compressed block, emits a header plus that
// channel's words, and discards the same block from every other channel.
module comp_select_n
    import comp_select_n_pkg::*;
#(
    parameter int NUM_CH     = 3,
    parameter int D_BITWIDTH = 64,
    parameter int S_BITWIDTH = 11,
    localparam int CH_W      = ch_w_of(NUM_CH)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NUM_CH*S_BITWIDTH-1:0] size_i,
    input  logic [NUM_CH-1:0]            size_empty_i,
    output logic                         size_rd_o,
    input  logic [NUM_CH*D_BITWIDTH-1:0] data_i,
    input  logic [NUM_CH-1:0]            data_empty_i,
    output logic [NUM_CH-1:0]            data_rd_o,
    output logic [D_BITWIDTH-1:0]        data_o,
    output logic                         valid_o,
    output logic                         sop_o,
    output logic                         eop_o,
    input  logic                         ready_i,
    output logic [CH_W-1:0]              sel_o,
    output logic                         busy_o
);

    localparam int WC_W    = S_BITWIDTH + 1;
    localparam int SEL_MSB = hdr_sel_msb(D_BITWIDTH);

    state_t                  state;
    logic [S_BITWIDTH-1:0]   size_q  [NUM_CH];
    logic [WC_W-1:0]         rem_q   [NUM_CH];
    logic [WC_W-1:0]         rem_nxt [NUM_CH];
    logic [CH_W-1:0]         sel_q;
    logic [NUM_CH*S_BITWIDTH-1:0] size_flat;
    logic [CH_W-1:0]         min_idx;
    logic [S_BITWIDTH-1:0]   min_val;
    logic                    size_avail;
    logic                    accept;
    logic                    all_done;

    function automatic logic [WC_W-1:0] wc_of(input logic [S_BITWIDTH-1:0] size);
        logic [31:0] t;
        t = 32'(size) + 32'(D_BITWIDTH - 1);
        return WC_W'(t / 32'(D_BITWIDTH));
    endfunction

    always_comb begin
        for (int k = 0; k < NUM_CH; k++) begin
            size_flat[k*S_BITWIDTH +: S_BITWIDTH] = size_q[k];
        end
    end

    comp_min_select #(
        .NUM_CH (NUM_CH),
        .VAL_W  (S_BITWIDTH)
    ) u_min (
        .vals    (size_flat),
        .min_idx (min_idx),
        .min_val (min_val)
    );

    assign size_avail = ~|size_empty_i;
    assign sel_o      = sel_q;
    assign busy_o     = (state != ST_IDLE);

    always_comb begin
        // Gated by rst_n so no pop escapes while the FIFOs are held in reset.
        size_rd_o = rst_n & (state == ST_IDLE) & size_avail;
        valid_o   = 1'b0;
        sop_o     = 1'b0;
        eop_o     = 1'b0;
        data_o    = '0;
        data_rd_o = '0;
        case (state)
            ST_HDR: begin
                valid_o = 1'b1;
                sop_o   = 1'b1;
                eop_o   = (rem_q[sel_q] == '0);
                data_o[SEL_MSB -: CH_W]              = sel_q;
                data_o[HDR_SIZE_LSB +: S_BITWIDTH]   = min_val;
            end
            ST_STREAM: begin
                valid_o = ~data_empty_i[sel_q];
                eop_o   = (rem_q[sel_q] == WC_W'(1));
                data_o  = data_i[int'(sel_q)*D_BITWIDTH +: D_BITWIDTH];
            end
            default: ;
        endcase
        accept = valid_o & ready_i;
        if (state == ST_STREAM) begin
            data_rd_o[sel_q] = accept;
        end
        // Losing channels are flushed at FIFO rate regardless of downstream backpressure.
        if (state == ST_HDR || state == ST_STREAM || state == ST_DRAIN) begin
            for (int k = 0; k < NUM_CH; k++) begin
                if (CH_W'(k) != sel_q && !data_empty_i[k] && rem_q[k] != '0) begin
                    data_rd_o[k] = 1'b1;
                end
            end
        end
        all_done = 1'b1;
        for (int k = 0; k < NUM_CH; k++) begin
            rem_nxt[k] = rem_q[k] - {{(WC_W-1){1'b0}}, data_rd_o[k]};
            if (rem_nxt[k] != '0) begin
                all_done = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            sel_q <= '0;
            for (int k = 0; k < NUM_CH; k++) begin
                size_q[k] <= '0;
                rem_q[k]  <= '0;
            end
        end else begin
            for (int k = 0; k < NUM_CH; k++) begin
                rem_q[k] <= rem_nxt[k];
            end
            case (state)
                ST_IDLE: begin
                    if (size_avail) begin
                        for (int k = 0; k < NUM_CH; k++) begin
                            size_q[k] <= size_i[k*S_BITWIDTH +: S_BITWIDTH];
                            rem_q[k]  <= wc_of(size_i[k*S_BITWIDTH +: S_BITWIDTH]);
                        end
                        state <= ST_SEL;
                    end
                end
                ST_SEL: begin
                    sel_q <= min_idx;
                    state <= ST_HDR;
                end
                ST_HDR: begin
                    if (ready_i) begin
                        if (rem_q[sel_q] != '0) begin
                            state <= ST_STREAM;
                        end else begin
                            state <= all_done ? ST_IDLE : ST_DRAIN;
                        end
                    end
                end
                ST_STREAM: begin
                    if (accept && rem_q[sel_q] == WC_W'(1)) begin
                        state <= all_done ? ST_IDLE : ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (all_done) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: doc/comp_select_n.md
COMP_SELECT_N -- requirements
Module: comp_select_n

Interface
REQ-001 Parameter NUM_CH, default 3: number of parallel compressor channels (2..8).
REQ-002 Parameter D_BITWIDTH, default 64: data word width.
REQ-003 Parameter S_BITWIDTH, default 11: per-block compressed size field, in bits.
REQ-004 Derived constant CH_W = max(1, clog2(NUM_CH)); it is not overridable.
REQ-005 clk  in  1: single clock; all state updates on the rising edge.
REQ-006 rst_n  in  1: reset, asynchronous and active-low.
REQ-007 size_i  in  NUM_CH*S_BITWIDTH: head of each channel size FIFO; channel k occupies bits [k*S_BITWIDTH +: S_BITWIDTH].
REQ-008 size_empty_i  in  NUM_CH: size FIFO empty flags.
REQ-009 size_rd_o  out  1: single pop strobe shared by all size FIFOs.
REQ-010 data_i  in  NUM_CH*D_BITWIDTH: head of each channel data FIFO.
REQ-011 data_empty_i  in  NUM_CH: data FIFO empty flags.
REQ-012 data_rd_o  out  NUM_CH: per-channel data FIFO pop strobes.
REQ-013 data_o  out  D_BITWIDTH: output word.
REQ-014 valid_o, sop_o, eop_o  out  1 each: output word qualifiers.
REQ-015 ready_i  in  1: downstream accepts the word when both valid_o and ready_i are high.
REQ-016 sel_o  out  CH_W: index of the winning channel for the current block.
REQ-017 busy_o  out  1: high in every state except IDLE.

Function
REQ-018 All FIFOs are show-ahead: the head word is valid whenever the FIFO's empty flag is low, and a pop advances it at the next edge.
REQ-019 FSM states: IDLE, SEL, HDR, STREAM, DRAIN.
REQ-020 IDLE -> SEL when all size_empty_i bits are low; size_rd_o pulses for one cycle on that transition.
REQ-021 The sizes are captured on the same edge as the size pop.
REQ-022 Word count per channel: wc[k] = ceil(size[k] / D_BITWIDTH), held at S_BITWIDTH+1 bits.
REQ-023 SEL lasts 1 cycle: the winner is the minimum size, ties go to the lowest index, and sel_o is registered here.
REQ-024 HDR: valid_o=1 and sop_o=1.
REQ-025 The HDR word is: data_o[D_BITWIDTH-1 -: CH_W] = sel, data_o[S_BITWIDTH-1:0] = size[sel], all other bits 0.
REQ-026 HDR advances to STREAM on ready_i, or to DRAIN on ready_i when wc[sel]=0; in the wc[sel]=0 case eop_o=1 together with sop_o.
REQ-027 STREAM: data_o = data_i[sel], and valid_o = !data_empty_i[sel].
REQ-028 data_rd_o[sel] = valid_o & ready_i.
REQ-029 eop_o = 1 on the last counted word.
REQ-030 STREAM -> DRAIN when the last word is accepted.
REQ-031 Discard: for each k != sel, data_rd_o[k] = !data_empty_i[k] & (remaining[k] > 0) in the HDR, STREAM and DRAIN states.
REQ-032 Discard is independent of ready_i.
REQ-033 DRAIN -> IDLE when every remaining[k] = 0; done in 0 cycles of DRAIN if already drained.
REQ-034 Outside HDR and STREAM: valid_o=0, sop_o=0, eop_o=0, data_o=0.
REQ-035 While valid_o=1 and ready_i=0, data_o, sop_o and eop_o hold stable.
REQ-036 No pop is ever issued to an empty FIFO.
REQ-037 IDLE -> SEL is not taken before DRAIN completes; the next block's sizes stay in their FIFOs.

Reset
REQ-038 Asserting rst_n low puts the block in IDLE and clears all counters, sel_o and size registers.
REQ-039 While rst_n is low, every output is 0.
REQ-040 A reset asserted mid-block abandons that block; the block does not flush the FIFOs (the FIFOs share the same reset).

Structure
REQ-041 A shared package holds CH_W, the header field positions and the FSM state encoding.
REQ-042 One sub-module: comp_min_select, a combinational NUM_CH-way minimum with lowest-index tie-break that returns the index and the minimum value.

Verification
REQ-043 NUM_CH=3, sizes {200,130,700}: header selects ch1 (sel=1, size=130), 3 words are streamed with eop_o on the 3rd, and the FIFOs of ch0 (4 words) and ch2 (11 words) fully drain.
REQ-044 Sizes {64,64,64}: ch0 is selected (tie-break), 1 data word is streamed, and ch1/ch2 each drain 1 word.
REQ-045 Selected size 0: a single header word with sop_o=eop_o=1 is output, followed only by drains of the other channels.
REQ-046 ready_i toggled 50% during STREAM: no word is duplicated or lost, data_o is stable while stalled, and the discard pops continue.
REQ-047 Selected data FIFO empty mid-block: valid_o drops and resumes once data arrives.
REQ-048 rst_n asserted during STREAM: all outputs go to 0 asynchronously, and after release the block returns to IDLE and takes the next block cleanly.
